// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-port arbiter/sequencer for a single-port SRAM; SRAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin
module sram_arb_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  logic [0:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, din_q, din_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, busy_q, busy_d, port_q, port_d, win;
`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic              last_q, last_d;
`endif
  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign sram_addr = addr_q;
  assign sram_we   = we_q;
  assign sram_din  = din_q;
  // winner among the current requesters (only meaningful when one requests)
  always_comb begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
    win = !req0;
`else
    win = (req0 && req1) ? !last_q : req1;
`endif
  end
  // IDLE latches the winner's command; ACCESS closes it and returns read data
  always_comb begin
    state_d  = state_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    port_d   = port_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    if (state_q == IDLE) begin
      if (req0 || req1) begin
        state_d = ACCESS;
        gnt_d   = win ? 2'b10 : 2'b01;
        busy_d  = 1'b1;
        port_d  = win;
        we_d    = win ? we1 : we0;
        addr_d  = win ? addr1 : addr0;
        din_d   = win ? wdata1 : wdata0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_d  = win;
`endif
      end
    end else begin
      state_d = IDLE;
      if (!we_q) begin
        rdata_d  = sram_dout;
        rvalid_d = port_q ? 2'b10 : 2'b01;
      end
    end
  end
  // state and registered outputs; reset leaves the last-grant pointer on port 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      port_q   <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      port_q   <= port_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: randomized and directed checks of sram_arb_ctrl against a transaction-level model
module tb_sram_arb_ctrl;
  typedef struct {logic we; logic [15:0] a; logic [7:0] d;} cmd_t;
  logic clk, rst_n, req0, req1, we0, we1;
  logic [15:0] addr0, addr1, sram_addr;
  logic [7:0] wdata0, wdata1, rdata, sram_din, sram_dout;
  logic gnt0, gnt1, rvalid0, rvalid1, busy, sram_we;
  logic [7:0] mem [65536];
  logic [7:0] ref_mem [65536];
  cmd_t q0[$], q1[$];
  int n_chk = 0, n_err = 0, rst_cnt = 1, m_port = 0, m_last = 1;
  bit eager = 1, rst_on_gnt = 0, m_busy = 0, m_we = 0;
  logic [15:0] m_addr = 0, exp_addr = 0;
  logic [7:0] m_din = 0, exp_din = 0, exp_rdata = 0;
  logic [1:0] exp_gnt = 0, exp_rv = 0;
  logic exp_busy = 0, exp_we = 0;

  sram_arb_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .busy(busy), .sram_addr(sram_addr), .sram_we(sram_we), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (sram_we) mem[sram_addr] <= sram_din;
  assign sram_dout = mem[sram_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transaction-level expectation for the outputs after the coming edge
  task automatic model();
    exp_gnt = 0;
    exp_rv = 0;
    exp_busy = 0;
    exp_we = 0;
    if (!rst_n) begin
      if (m_busy && m_we) ref_mem[m_addr] = m_din;
      m_busy = 0;
      m_last = 1;
      exp_rdata = 0;
      exp_addr = 0;
      exp_din = 0;
    end else if (m_busy) begin
      if (m_we) ref_mem[m_addr] = m_din;
      else begin
        exp_rv[m_port] = 1'b1;
        exp_rdata = ref_mem[m_addr];
      end
      m_busy = 0;
    end else if (req0 || req1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      m_port = req0 ? 0 : 1;
`else
      m_port = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
`endif
      m_last = m_port;
      m_we = m_port == 1 ? we1 : we0;
      m_addr = m_port == 1 ? addr1 : addr0;
      m_din = m_port == 1 ? wdata1 : wdata0;
      m_busy = 1;
      exp_gnt[m_port] = 1'b1;
      exp_busy = 1;
      exp_we = m_we;
      exp_addr = m_addr;
      exp_din = m_din;
    end
  endtask

  // Requesters: hold a command until granted, then drop req or present the next one
  task automatic drive();
    if (rst_on_gnt && gnt0) begin
      rst_cnt = 1;
      rst_on_gnt = 0;
    end
    rst_n = (rst_cnt == 0);
    if (rst_cnt != 0) rst_cnt--;
    if (gnt0 && req0) begin
      q0.delete(0);
      req0 = 0;
    end
    if (gnt1 && req1) begin
      q1.delete(0);
      req1 = 0;
    end
    if (!req0 && q0.size() != 0 && (eager || $urandom_range(0, 2) == 0)) begin
      req0 = 1;
      we0 = q0[0].we;
      addr0 = q0[0].a;
      wdata0 = q0[0].d;
    end
    if (!req1 && q1.size() != 0 && (eager || $urandom_range(0, 2) == 0)) begin
      req1 = 1;
      we1 = q1[0].we;
      addr1 = q1[0].a;
      wdata1 = q1[0].d;
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, exp_gnt});
    chk("rvalid", {30'd0, rvalid1, rvalid0}, {30'd0, exp_rv});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("sram_we", {31'd0, sram_we}, {31'd0, exp_we});
    chk("sram_addr", {16'd0, sram_addr}, {16'd0, exp_addr});
    chk("sram_din", {24'd0, sram_din}, {24'd0, exp_din});
    chk("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
    drive();
    model();
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || req0 || req1 || m_busy || !rst_n || rst_cnt != 0) && n < 5000) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 5000 ? 32'd1 : 32'd0, 32'd1);
    repeat (2) step();
  endtask

  function automatic cmd_t mk(input logic we, input logic [15:0] a, input logic [7:0] d);
    cmd_t c;
    c.we = we;
    c.a = a;
    c.d = d;
    return c;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst_n = 0;
    req0 = 0;
    req1 = 0;
    we0 = 0;
    we1 = 0;
    addr0 = 0;
    addr1 = 0;
    wdata0 = 0;
    wdata1 = 0;
    model();
    drain();
    q0.push_back(mk(1, 16'h0001, 8'hAA));
    q0.push_back(mk(0, 16'h0001, 8'h00));
    drain();
    chk("single_rdata", {24'd0, rdata}, 32'hAA);
    mem[16] = 8'h55;
    ref_mem[16] = 8'h55;
    q0.push_back(mk(0, 16'h0010, 8'h00));
    q1.push_back(mk(0, 16'h0010, 8'h00));
    rst_cnt = 1;
    drain();
    chk("tie_rdata", {24'd0, rdata}, 32'h55);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1, 16'(i), 8'(i)));
      q1.push_back(mk(1, 16'(8'h80 + i), 8'(8'h80 + i)));
    end
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(0, 16'(i), 8'h00));
      q1.push_back(mk(0, 16'(8'h80 + i), 8'h00));
    end
    drain();
    q0.push_back(mk(1, 16'hFFFF, 8'h5A));
    q1.push_back(mk(1, 16'h0000, 8'hA5));
    q0.push_back(mk(0, 16'hFFFF, 8'h00));
    q1.push_back(mk(0, 16'h0000, 8'h00));
    drain();
    chk("wrap_ffff", {24'd0, ref_mem[16'hFFFF]}, 32'h5A);
    rst_on_gnt = 1;
    q0.push_back(mk(1, 16'h1234, 8'h3C));
    drain();
    q1.push_back(mk(0, 16'h1234, 8'h00));
    drain();
    chk("rst_write_rdata", {24'd0, rdata}, 32'h3C);
    eager = 0;
    for (int i = 0; i < 150; i++) begin
      q0.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom)));
      q1.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom)));
    end
    drain();
    eager = 1;
    for (int i = 0; i < 20; i++) begin
      q0.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom)));
      q1.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom)));
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
